// File: rtl/rram_mux_prog_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : rram_prog_pkg
// Purpose  : Shared types and helpers for the RRAM mux programming
//            sequencer: the sequencer state encoding and a one-hot
//            vector builder used for the bit-line / word-line drives.
// Contents : rram_prog_state_t  - sequencer state enum
//            onehot(idx, width) - ascending-range one-hot vector
// Revision : 1.0 - initial release
// ============================================================================
package rram_prog_pkg;

    // Widest bl/wl bus the onehot() helper can build.
    localparam int unsigned c_ONEHOT_MAX_W = 64;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        RST_PULSE = 3'd1,
        RST_GAP   = 3'd2,
        SET_PULSE = 3'd3,
        SET_GAP   = 3'd4,
        DONE      = 3'd5
    } rram_prog_state_t;

    // Bit 'idx' of an ascending [0:N-1] vector is set; bits at or beyond
    // 'width' are never set, so an out-of-range index yields all zeros.
    function automatic logic [0:c_ONEHOT_MAX_W-1] onehot(
        input int unsigned idx,
        input int unsigned width
    );
        logic [0:c_ONEHOT_MAX_W-1] v;
        v = '0;
        if ((idx < width) && (idx < c_ONEHOT_MAX_W)) begin
            v[idx[5:0]] = 1'b1;
        end
        return v;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rram_mux_prog_ctrl_pulse_timer.sv
`default_nettype none
// ============================================================================
// Module   : rram_prog_pulse_timer
// Purpose  : Loadable down-counter timing the programming pulse and the
//            idle gap that follows it. Loading N-1 makes 'expire' assert
//            in the N-th cycle after the load edge.
// Ports    : prog_clock  in   programming clock
//            prog_rst_n  in   asynchronous active-low reset
//            load        in   load 'load_value' on the next edge
//            load_value  in   CNT_W-bit reload value (duration - 1)
//            expire      out  count has reached zero
// Revision : 1.0 - initial release
// ============================================================================
module rram_prog_pulse_timer
    import rram_prog_pkg::*;
#(
    parameter int CNT_W = 1
) (
    input  logic             prog_clock,
    input  logic             prog_rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_value,
    output logic             expire
);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge prog_clock or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_count <= '0;
        end else if (load) begin
            r_count <= load_value;
        end else if (r_count != '0) begin
            r_count <= r_count - CNT_W'(1);
        end
    end

    assign expire = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rram_mux_prog_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : rram_mux_prog_ctrl
// Purpose  : Programming sequencer for one 4T1R 1-level RRAM multiplexer.
//            On an accepted start it resets every RRAM of the mux to high
//            resistance (one pulse per input), then sets the single RRAM
//            that routes the latched input to the output.
// Ports    : prog_clock   in   programming clock
//            prog_rst_n   in   asynchronous active-low reset
//            start        in   programming request (sampled on rising edge)
//            sel          in   input index to route, latched on accept
//            busy         out  sequence in progress
//            done         out  one-cycle completion pulse
//            config_done  out  mux holds a valid configuration
//            err          out  one-cycle pulse, start rejected (sel too big)
//            bl, wl       out  one-hot bit / word lines, [0:SIZE_OF_MUX]
//            prog_EN      out  programming enable
//            prog_ENb     out  complement of prog_EN
// Revision : 1.0 - initial release
// ============================================================================
module rram_mux_prog_ctrl
    import rram_prog_pkg::*;
#(
    parameter  int SIZE_OF_MUX  = 4,
    parameter  int SEL_WIDTH    = 2,
    parameter  int PULSE_CYCLES = 2,
    parameter  int GAP_CYCLES   = 1,
    localparam int SIZE_OF_BLWL = SIZE_OF_MUX + 1
) (
    input  logic                  prog_clock,
    input  logic                  prog_rst_n,
    input  logic                  start,
    input  logic [SEL_WIDTH-1:0]  sel,
    output logic                  busy,
    output logic                  done,
    output logic                  config_done,
    output logic                  err,
    output logic [0:SIZE_OF_BLWL-1] bl,
    output logic [0:SIZE_OF_BLWL-1] wl,
    output logic                  prog_EN,
    output logic                  prog_ENb
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int c_IDX_W      = $clog2(SIZE_OF_MUX);
    localparam int c_LAST_INT   = SIZE_OF_MUX - 1;
    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_LAST_INT[c_IDX_W-1:0];

    // sel is compared one bit wider so SIZE_OF_MUX == 2**SEL_WIDTH works.
    localparam logic [SEL_WIDTH:0] c_SEL_LIMIT = SIZE_OF_MUX[SEL_WIDTH:0];

    localparam int c_MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W      = (c_MAX_CYCLES > 1) ? $clog2(c_MAX_CYCLES) : 1;
    localparam int c_PULSE_M1   = PULSE_CYCLES - 1;
    localparam int c_GAP_M1     = GAP_CYCLES - 1;
    localparam logic [c_CNT_W-1:0] c_PULSE_LOAD = c_PULSE_M1[c_CNT_W-1:0];
    localparam logic [c_CNT_W-1:0] c_GAP_LOAD   = c_GAP_M1[c_CNT_W-1:0];

    // One-hot line vector sized to this mux's bl/wl bus.
    function automatic logic [0:SIZE_OF_BLWL-1] blwl_onehot(input int unsigned idx);
        logic [0:c_ONEHOT_MAX_W-1] full;
        full = onehot(idx, SIZE_OF_BLWL);
        return full[0:SIZE_OF_BLWL-1];
    endfunction

    // ------------------------------------------------------------------
    // State and output registers
    // ------------------------------------------------------------------
    rram_prog_state_t          r_state;
    logic [c_IDX_W-1:0]        r_idx;
    logic [SEL_WIDTH-1:0]      r_sel;
    logic                      r_busy;
    logic                      r_done;
    logic                      r_config_done;
    logic                      r_err;
    logic [0:SIZE_OF_BLWL-1]   r_bl;
    logic [0:SIZE_OF_BLWL-1]   r_wl;
    logic                      r_prog_en;
    logic                      r_prog_enb;

    logic                      w_sel_valid;
    logic                      w_accept;
    logic                      w_expire;
    logic                      w_tmr_load;
    logic [c_CNT_W-1:0]        w_tmr_value;

    assign w_sel_valid = ({1'b0, sel} < c_SEL_LIMIT);
    assign w_accept    = start && w_sel_valid &&
                         ((r_state == IDLE) || (r_state == DONE));

    // The timer is reloaded on every edge that enters a timed state, with
    // the duration of the state being entered: pulses follow IDLE/DONE and
    // RST_GAP, gaps follow the pulse states. Leaving SET_GAP reloads too;
    // the value is unused there because DONE is untimed.
    always_comb begin
        w_tmr_load  = 1'b0;
        w_tmr_value = c_PULSE_LOAD;
        case (r_state)
            IDLE, DONE: begin
                w_tmr_load = w_accept;
            end
            RST_PULSE, SET_PULSE: begin
                w_tmr_load  = w_expire;
                w_tmr_value = c_GAP_LOAD;
            end
            RST_GAP, SET_GAP: begin
                w_tmr_load = w_expire;
            end
            default: begin
                w_tmr_load = 1'b0;
            end
        endcase
    end

    rram_prog_pulse_timer #(
        .CNT_W (c_CNT_W)
    ) u_pulse_timer (
        .prog_clock (prog_clock),
        .prog_rst_n (prog_rst_n),
        .load       (w_tmr_load),
        .load_value (w_tmr_value),
        .expire     (w_expire)
    );

    // Outputs are registered together with the state transition so the
    // line drive for a state is visible in the first cycle of that state.
    always_ff @(posedge prog_clock or negedge prog_rst_n) begin
        if (!prog_rst_n) begin
            r_state       <= IDLE;
            r_idx         <= '0;
            r_sel         <= '0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_config_done <= 1'b0;
            r_err         <= 1'b0;
            r_bl          <= '0;
            r_wl          <= '0;
            r_prog_en     <= 1'b0;
            r_prog_enb    <= 1'b1;
        end else begin
            r_done <= 1'b0;
            r_err  <= 1'b0;
            case (r_state)
                IDLE, DONE: begin
                    r_state <= IDLE;
                    if (start) begin
                        if (w_sel_valid) begin
                            // First reset pulse: common bit line, word line 0.
                            r_state       <= RST_PULSE;
                            r_sel         <= sel;
                            r_idx         <= '0;
                            r_config_done <= 1'b0;
                            r_busy        <= 1'b1;
                            r_bl          <= blwl_onehot(SIZE_OF_MUX);
                            r_wl          <= blwl_onehot(0);
                            r_prog_en     <= 1'b1;
                            r_prog_enb    <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                RST_PULSE: begin
                    if (w_expire) begin
                        r_state    <= RST_GAP;
                        r_bl       <= '0;
                        r_wl       <= '0;
                        r_prog_en  <= 1'b0;
                        r_prog_enb <= 1'b1;
                    end
                end
                RST_GAP: begin
                    if (w_expire) begin
                        r_prog_en  <= 1'b1;
                        r_prog_enb <= 1'b0;
                        if (r_idx < c_IDX_LAST) begin
                            r_state <= RST_PULSE;
                            r_idx   <= r_idx + c_IDX_W'(1);
                            r_bl    <= blwl_onehot(SIZE_OF_MUX);
                            r_wl    <= blwl_onehot(32'(r_idx) + 32'd1);
                        end else begin
                            // All inputs reset; set the selected path.
                            r_state <= SET_PULSE;
                            r_bl    <= blwl_onehot(32'(r_sel));
                            r_wl    <= blwl_onehot(SIZE_OF_MUX);
                        end
                    end
                end
                SET_PULSE: begin
                    if (w_expire) begin
                        r_state    <= SET_GAP;
                        r_bl       <= '0;
                        r_wl       <= '0;
                        r_prog_en  <= 1'b0;
                        r_prog_enb <= 1'b1;
                    end
                end
                SET_GAP: begin
                    if (w_expire) begin
                        r_state       <= DONE;
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_config_done <= 1'b1;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_busy     <= 1'b0;
                    r_bl       <= '0;
                    r_wl       <= '0;
                    r_prog_en  <= 1'b0;
                    r_prog_enb <= 1'b1;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign config_done = r_config_done;
    assign err         = r_err;
    assign bl          = r_bl;
    assign wl          = r_wl;
    assign prog_EN     = r_prog_en;
    assign prog_ENb    = r_prog_enb;

endmodule
`default_nettype wire
